// File: rtl/ssd_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl_if
//
// Purpose : bundles the host-side write port and the display-side outputs of
//           the seven-segment scan controller into one interface.
//
// Parameters
//   NUM_DIGITS : number of multiplexed digits (sets the anode width)
//   AW         : digit address width
//
// Signals
//   en       : display enable (host -> controller)
//   wr_en    : digit register write strobe (host -> controller)
//   wr_addr  : digit index to write (host -> controller)
//   wr_data  : 4-bit hex value to store (host -> controller)
//   wr_dp    : decimal-point bit to store (host -> controller)
//   seg      : active-low segments, seg[6]=a .. seg[0]=g (controller -> pins)
//   dp       : active-low decimal point (controller -> pins)
//   an       : active-low digit anodes, an[i] low selects digit i
//
// Modports
//   master : the host / testbench side that drives the write port
//   slave  : the scan controller itself
// ---------------------------------------------------------------------------
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int AW         = $clog2(NUM_DIGITS)
);
    logic                  en;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [3:0]            wr_data;
    logic                  wr_dp;
    logic [6:0]            seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output en,
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_dp,
        input  seg,
        input  dp,
        input  an
    );

    modport slave (
        input  en,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  wr_dp,
        output seg,
        output dp,
        output an
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
//
// Purpose : multiplexed seven-segment display scan controller. Holds one
//           4-bit hex value plus a decimal-point bit per digit, steps a scan
//           index through the digits every REFRESH_DIV clocks and drives
//           registered, active-low segment / dp / anode outputs for the digit
//           currently selected.
//
// Parameters
//   NUM_DIGITS  : number of multiplexed digits, 2..16
//   REFRESH_DIV : clocks each digit stays lit, 1..2^24
//   AW          : digit address width
//
// Ports
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous active-high reset; clears digits, counter, index and
//         forces the outputs to their blank (all-ones) state
//   bus : ssd_scan_ctrl_if.slave
//           en / wr_en / wr_addr / wr_data / wr_dp  in
//           seg / dp / an                           out
//
// Build option
//   SSD_LEADING_ZERO_BLANK_EN : when defined, a digit whose value and all
//   higher-index digit values are zero shows a blank segment pattern (dp and
//   anode behave as normal). Digit 0 is never blanked. When undefined no
//   blanking logic is built.
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int AW          = $clog2(NUM_DIGITS)
) (
    input  logic           clk,
    input  logic           rst,
    ssd_scan_ctrl_if.slave bus
);

    // Refresh counter wide enough for REFRESH_DIV-1; a divide of 1 still
    // needs a 1-bit register that simply sits at zero.
    localparam int               CW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [AW-1:0]    SCAN_LAST   = AW'(NUM_DIGITS - 1);
    localparam int               AWP         = AW + 1;
    // One extra bit so the range compare is meaningful even when NUM_DIGITS
    // is an exact power of two.
    localparam logic [AWP-1:0]   DIGIT_LIMIT = AWP'(NUM_DIGITS);
    localparam logic [6:0]       SEG_BLANK   = 7'h7F;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [AW-1:0]         scan_q;
    logic [AW-1:0]         scan_d;

    logic [3:0]            val_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dig_dp_q;

    logic [6:0]            seg_q;
    logic [6:0]            seg_d;
    logic                  dp_out_q;
    logic                  dp_out_d;
    logic [NUM_DIGITS-1:0] an_q;
    logic [NUM_DIGITS-1:0] an_d;

    // -----------------------------------------------------------------------
    // Digit register file write decode
    // -----------------------------------------------------------------------
    logic                  addr_ok;
    logic [NUM_DIGITS-1:0] wr_hit;

    assign addr_ok = ({1'b0, bus.wr_addr} < DIGIT_LIMIT);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr_dec
            assign wr_hit[gi] = bus.wr_en && addr_ok && (bus.wr_addr == AW'(gi));
        end
    endgenerate

    // The digit file must clear on reset, so it is kept in flops rather than
    // a memory macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                val_q[i] <= 4'd0;
            end
            dig_dp_q <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_hit[i]) begin
                    val_q[i]    <= bus.wr_data;
                    dig_dp_q[i] <= bus.wr_dp;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Refresh counter and scan index (free-running, independent of en)
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        scan_d = scan_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            scan_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            scan_q <= scan_d;
        end
    end

    // -----------------------------------------------------------------------
    // Current digit selection and hex decode
    // -----------------------------------------------------------------------
    logic [3:0] cur_val;
    logic       cur_dp;
    logic [6:0] seg_hex;

    assign cur_val = val_q[scan_q];
    assign cur_dp  = dig_dp_q[scan_q];

    // Active-low patterns, bit 6 = segment a down to bit 0 = segment g.
    always_comb begin
        seg_hex = SEG_BLANK;
        case (cur_val)
            4'h0: seg_hex = 7'h01;
            4'h1: seg_hex = 7'h4F;
            4'h2: seg_hex = 7'h12;
            4'h3: seg_hex = 7'h06;
            4'h4: seg_hex = 7'h4C;
            4'h5: seg_hex = 7'h24;
            4'h6: seg_hex = 7'h20;
            4'h7: seg_hex = 7'h0F;
            4'h8: seg_hex = 7'h00;
            4'h9: seg_hex = 7'h04;
            4'hA: seg_hex = 7'h08;
            4'hB: seg_hex = 7'h60;
            4'hC: seg_hex = 7'h31;
            4'hD: seg_hex = 7'h42;
            4'hE: seg_hex = 7'h30;
            4'hF: seg_hex = 7'h38;
        endcase
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; the run of zeros stays
    // alive only while every digit so far holds zero. Digit 0 always shows.
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_run;
    logic                  cur_blank;

    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (val_q[i] == 4'd0);
            blank_vec[i] = zero_run && (i != 0);
        end
    end

    assign cur_blank = blank_vec[scan_q];
    assign seg_d     = cur_blank ? SEG_BLANK : seg_hex;
`else
    assign seg_d = seg_hex;
`endif

    assign dp_out_d = ~cur_dp;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_d[gi] = (scan_q != AW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Registered outputs; disabled display is dark but scanning carries on.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_out_q <= 1'b1;
        end else if (!bus.en) begin
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_out_q <= 1'b1;
        end else begin
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_out_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_ctrl
//
// Drives an 8-digit (divide 4) and a 6-digit (divide 3) controller with the
// same stimulus. The reference model tracks digit contents in arrays and
// derives the scan position from the number of clocks since reset release:
// index = (clocks / REFRESH_DIV) mod NUM_DIGITS.
// ---------------------------------------------------------------------------
module tb_ssd_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b0;
    logic       en      = 1'b0;
    logic       wr_en   = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dp   = 1'b0;

    ssd_scan_ctrl_if #(.NUM_DIGITS(8)) bus8 ();
    ssd_scan_ctrl_if #(.NUM_DIGITS(6)) bus6 ();

    assign bus8.en      = en;
    assign bus8.wr_en   = wr_en;
    assign bus8.wr_addr = wr_addr;
    assign bus8.wr_data = wr_data;
    assign bus8.wr_dp   = wr_dp;
    assign bus6.en      = en;
    assign bus6.wr_en   = wr_en;
    assign bus6.wr_addr = wr_addr;
    assign bus6.wr_data = wr_data;
    assign bus6.wr_dp   = wr_dp;

    ssd_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    ssd_scan_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] m_val [2][16];
    logic       m_dp  [2][16];
    logic [7:0] exp_an  [2];
    logic [6:0] exp_seg [2];
    logic       exp_dp  [2];
    // Lit segments, active-high, bit 6 = a .. bit 0 = g.
    logic [6:0] lit [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic int n_of(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    // Expected outputs after this edge, from the state before it.
    task automatic predict();
        int n;
        int idx;
        bit blank;
        for (int k = 0; k < 2; k++) begin
            n   = n_of(k);
            idx = (cyc / div_of(k)) % n;
            if (rst || !en) begin
                exp_an[k]  = 8'((1 << n) - 1);
                exp_seg[k] = 7'h7F;
                exp_dp[k]  = 1'b1;
            end else begin
                blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                if (idx != 0) begin
                    blank = 1'b1;
                    for (int j = idx; j < n; j++) begin
                        if (m_val[k][j] != 4'd0) blank = 1'b0;
                    end
                end
`endif
                exp_an[k]  = 8'(((1 << n) - 1) & ~(1 << idx));
                exp_seg[k] = blank ? 7'h7F : ~lit[m_val[k][idx]];
                exp_dp[k]  = ~m_dp[k][idx];
            end
        end
    endtask

    task automatic update();
        if (!rst) begin
            if (wr_en) begin
                $display("wr addr=%0d data=%h dp=%0d en=%0d cyc=%0d", wr_addr, wr_data, wr_dp, en, cyc);
                for (int k = 0; k < 2; k++) begin
                    if (int'(wr_addr) < n_of(k)) begin
                        m_val[k][wr_addr] = wr_data;
                        m_dp[k][wr_addr]  = wr_dp;
                    end
                end
            end
            cyc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        predict();
        update();
        #1;
        check("an8",  32'(bus8.an),  32'(exp_an[0]));
        check("seg8", 32'(bus8.seg), 32'(exp_seg[0]));
        check("dp8",  32'(bus8.dp),  32'(exp_dp[0]));
        check("an6",  32'(bus6.an),  32'(exp_an[1]));
        check("seg6", 32'(bus6.seg), 32'(exp_seg[1]));
        check("dp6",  32'(bus6.dp),  32'(exp_dp[1]));
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 16; j++) begin
                m_val[k][j] = 4'd0;
                m_dp[k][j]  = 1'b0;
            end
        end
        cyc = 0;
    endtask

    // Reset takes effect without a clock edge; checked 1 time unit later.
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        #1;
        check("rst_an8",  32'(bus8.an),  32'h0000_00FF);
        check("rst_seg8", 32'(bus8.seg), 32'h0000_007F);
        check("rst_dp8",  32'(bus8.dp),  32'h0000_0001);
        check("rst_an6",  32'(bus6.an),  32'h0000_003F);
        check("rst_seg6", 32'(bus6.seg), 32'h0000_007F);
        check("rst_dp6",  32'(bus6.dp),  32'h0000_0001);
        model_clear();
        for (int i = 0; i < ncyc; i++) step();
        rst = 1'b0;
    endtask

    task automatic write(input int addr, input int data, input bit dpv);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 4'(data);
        wr_dp   = dpv;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        lit = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        model_clear();
        en = 1'b1;
        #1;
        do_reset(3);

        // Release: first edge shows digit 0 holding 0.
        step();
        step();

        // Digit i = i+1, then watch at least one full scan and wrap.
        for (int i = 0; i < 8; i++) write(i, i + 1, 1'b0);
        for (int i = 0; i < 40; i++) step();

        // Align to the start of digit 0's slot and overwrite it.
        for (int g = 0; g < 64 && (cyc % 32) != 0; g++) step();
        check("align", 32'(cyc % 32), 32'd0);
        write(0, 4'hF, 1'b1);
        step();
        step();

        // Display off for 10 clocks, then back on.
        en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        en = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Reset in the middle of a digit slot.
        for (int i = 0; i < 5; i++) step();
        do_reset(2);
        step();

        // Leading-zero pattern: only digit 2 non-zero.
        for (int i = 0; i < 8; i++) write(i, 0, 1'b0);
        write(2, 5, 1'b0);
        for (int i = 0; i < 40; i++) step();

        // Randomized traffic, including out-of-range addresses for the
        // 6-digit instance and occasional resets.
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 3)));
            en      = ($urandom_range(0, 7) != 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            wr_dp   = 1'($urandom);
            step();
        end
        wr_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
- REQ-001: Parameter NUM_DIGITS, default 8, number of multiplexed digits, legal range 2..16.
- REQ-002: Parameter REFRESH_DIV, default 100000, clock cycles each digit is displayed, legal range 1 to 2^24.
- REQ-003: Parameter AW, default $clog2(NUM_DIGITS), width of the digit address.
- REQ-004: Port clk, input, 1 bit, single clock, all state updates on its rising edge.
- REQ-005: Port rst, input, 1 bit, reset, asynchronous and active-high.
- REQ-006: Port en, input, 1 bit, display enable.
- REQ-007: Port wr_en, input, 1 bit, write strobe for the digit register file.
- REQ-008: Port wr_addr, input, AW bits, index of the digit to write.
- REQ-009: Port wr_data, input, 4 bits, hex value to store.
- REQ-010: Port wr_dp, input, 1 bit, decimal-point value to store.
- REQ-011: Port seg, output, 7 bits, active-low segments, seg[6]=a down to seg[0]=g.
- REQ-012: Port dp, output, 1 bit, active-low decimal point.
- REQ-013: Port an, output, NUM_DIGITS bits, active-low digit anodes, an[i] low selects digit i.

Function
- REQ-014: The block SHALL hold NUM_DIGITS digit registers, each 4-bit value plus 1-bit dp.
- REQ-015: On a clk edge with wr_en=1 and wr_addr<NUM_DIGITS, the digit register wr_addr SHALL load wr_data and wr_dp.
- REQ-016: A write with wr_addr>=NUM_DIGITS SHALL be ignored.
- REQ-017: A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; it runs regardless of en.
- REQ-018: At refresh terminal count, scan index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
- REQ-019: seg, dp and an SHALL be registered and computed every cycle from the current scan index and digit register (1-cycle latency).
- REQ-020: Decode SHALL be standard hex 0-F, active-low: 0=7'h01, 4=7'h4C, 5=7'h24, 8=7'h00, F=7'h38.
- REQ-021: When en=1, an SHALL drive exactly one low bit, at the scan index.
- REQ-022: When en=1, dp SHALL equal the inverted stored dp of that digit.
- REQ-023: When en=0, an SHALL be all ones, seg 7'h7F and dp 1 on the next edge; scanning continues.
- REQ-024: A write to the currently scanned digit SHALL appear on seg one edge after the write edge.
- REQ-025: A write coinciding with a scan advance SHALL be stored, with the new index displayed normally.

Reset
- REQ-026: Asserting rst SHALL immediately clear all digit values and dp bits, the refresh counter and the scan index.
- REQ-027: While rst is asserted, outputs SHALL be an all ones, seg 7'h7F and dp 1.
- REQ-028: Reset mid-scan SHALL abort the current digit; after release the scan restarts at digit 0 with a full REFRESH_DIV period.

Configuration
- REQ-029: Macro SSD_LEADING_ZERO_BLANK_EN, when defined, SHALL blank leading zeros.
  - A digit is blanked when it and all higher-index digits hold value 0: seg=7'h7F, dp still per stored bit, anode still asserted.
  - Digit 0 is never blanked.
- REQ-030: Without SSD_LEADING_ZERO_BLANK_EN, every digit SHALL be decoded normally, with no blanking logic present.

Verification (NUM_DIGITS=8, REFRESH_DIV=4)
- REQ-031: Reset check.
  - Stimulus: rst=1, then release with en=1.
  - Response: during reset an=8'hFF, seg=7'h7F, dp=1; first edge after release an=8'hFE, seg=7'h01.
- REQ-032: Scan order and wrap.
  - Stimulus: write digit i = i+1 for i=0..7.
  - Response: an steps FE,FD,FB,...,7F every 4 cycles, then back to FE; when an=8'hF7, seg=7'h4C.
- REQ-033: Write to the scanned digit.
  - Stimulus: while an=8'hFE, write addr 0 data F, dp=1.
  - Response: next edge seg=7'h38, dp=0.
- REQ-034: Display disable.
  - Stimulus: en=0 for 10 cycles, then en=1.
  - Response: an=8'hFF throughout; after re-enable the index has advanced by 2 or 3 digits, per the running counter.
- REQ-035: Out-of-range write is not applicable at 8 digits.
  - Stimulus: with NUM_DIGITS=6, write addr 7.
  - Response: no digit register changes.
- REQ-036: Leading-zero blanking (macro defined).
  - Stimulus: all digits 0 except digit 2=5.
  - Response: digits 7..3 show seg=7'h7F, digit 2 shows 7'h24, digits 1 and 0 show 7'h01.
